// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receive deserializer.
// Synchronises and glitch-filters the PS/2 clock and data lines. Each frame is
// a start bit, 8 data bits (LSB first), an odd parity bit and a stop bit.
// Every good byte is presented with a one-cycle valid strobe. Bad or stalled
// frames raise a one-cycle error strobe together with a sticky error code.
module ps2_rx_deserializer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic [FW-1:0]          filt_cnt;
    logic                   filt_clk, filt_clk_q;
    logic                   strobe;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   par_acc;
    logic [TW-1:0]          tmo_cnt;
    logic                   tmo_hit;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign dat_s  = dat_sync[SYNC_STAGES-1];
    assign strobe = filt_clk_q & ~filt_clk;
    assign busy   = (state != S_IDLE);

    // Input synchronisers, preset high so a reset looks like an idle bus
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
        end
    end

    // Clock filter: follows the synced clock only after FILTER_LEN consecutive
    // cycles of disagreement; any agreeing cycle restarts the count
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_q <= 1'b1;
        end else begin
            filt_clk_q <= filt_clk;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame state register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_d;
    end

    // Next state; a strobe on the terminal timeout count keeps the frame alive
    always_comb begin
        state_d = state;
        tmo_hit = 1'b0;
        if (state != S_IDLE && !strobe && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            tmo_hit = 1'b1;
            state_d = S_IDLE;
        end else if (strobe) begin
            unique case (state)
                S_IDLE:   if (!dat_s) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: shift register, running parity, stall timer and result strobes
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
            tmo_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;

            if (state == S_IDLE || strobe || tmo_hit) tmo_cnt <= '0;
            else                                      tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                rx_err   <= 1'b1;
                err_code <= 2'b11;
            end else if (strobe) begin
                unique case (state)
                    S_IDLE: begin
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                    S_DATA: begin
                        shift_reg <= {dat_s, shift_reg[7:1]};
                        par_acc   <= par_acc ^ dat_s;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_acc <= par_acc ^ dat_s;
                    S_STOP: begin
                        // a missing stop bit is reported ahead of a parity fault
                        if (!dat_s) begin
                            rx_err   <= 1'b1;
                            err_code <= 2'b10;
                        end else if (par_acc) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_err   <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Self-checking bench for ps2_rx_deserializer. Frames are driven as PS/2
// waveforms; a frame-level model queues the expected outcome of each frame,
// and a compare process checks the outputs against it on every cycle.
module tb_ps2_rx_deserializer;
    localparam int SYNC = 2;
    localparam int FLEN = 8;
    localparam int TMO  = 5000;
    // drive-to-pulse: first edge, SYNC flops, FLEN filter cycles, result register
    localparam int LAT  = SYNC + FLEN + 1;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       ps2_clk_in, ps2_dat_in;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err, busy;
    logic [1:0] err_code;

    ps2_rx_deserializer #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .err_code(err_code), .busy(busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic [1:0] code;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_code = 2'b00;
    logic prev_pulse = 1'b0;
    logic prev_busy = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Outcome of a complete frame from the framing rules alone
    function automatic exp_t frame_result(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.data = d;
        if (!stp) begin
            e.is_err = 1'b1; e.code = 2'b10;
        end else if ((^d ^ par) != 1'b1) begin
            e.is_err = 1'b1; e.code = 2'b01;
        end else begin
            e.is_err = 1'b0; e.code = 2'b00;
        end
        return e;
    endfunction

    // Per-cycle compare against the model
    always begin
        @(negedge CLOCK_50);
        #1;
        if (!resetn) begin
            chk("reset rx_data", int'(rx_data), 0);
            chk("reset rx_valid", int'(rx_valid), 0);
            chk("reset rx_err", int'(rx_err), 0);
            chk("reset err_code", int'(err_code), 0);
            chk("reset busy", int'(busy), 0);
            q.delete();
            m_data = 8'h00;
            m_code = 2'b00;
            prev_pulse = 1'b0;
        end else begin
            if (rx_valid && rx_err) chk("valid and err together", 1, 0);
            if (rx_valid || rx_err) begin
                chk("pulse width", int'(prev_pulse), 0);
                chk("busy at pulse", int'(busy), 0);
                chk("busy before pulse", int'(prev_busy), 1);
                if (q.size() == 0) begin
                    chk("unexpected pulse", int'(rx_err), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse kind err", int'(rx_err), int'(e.is_err));
                    if (e.is_err) m_code = e.code;
                    else          m_data = e.data;
                end
            end
            chk("rx_data", int'(rx_data), int'(m_data));
            chk("err_code", int'(err_code), int'(m_code));
            prev_pulse = rx_valid | rx_err;
        end
        prev_busy = busy;
    end

    // Drive one frame (or its first nbits bits). Optional clock glitch high
    // inside the low half of glitch_bit, optional reset pulse after rst_bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int nbits, input int half, input int glitch_bit,
                              input int rst_bit);
        logic [10:0] fr;
        logic want, seen;
        fr = {stp, par, d, 1'b0};
        want = (nbits == 11) && (rst_bit < 0);
        seen = 1'b0;
        if (want) q.push_back(frame_result(d, par, stp));
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            ps2_dat_in = fr[i];
            repeat (half - 1) @(negedge CLOCK_50);
            ps2_clk_in = 1'b0;
            last_fall_cyc = cyc;
            if (i == glitch_bit) begin
                repeat (15) @(negedge CLOCK_50);
                ps2_clk_in = 1'b1;
                repeat (5) @(negedge CLOCK_50);
                ps2_clk_in = 1'b0;
                repeat (half - 20) @(negedge CLOCK_50);
            end else begin
                for (int j = 0; j < half; j++) begin
                    @(negedge CLOCK_50);
                    if (i == 10 && want && !seen && (rx_valid || rx_err)) begin
                        seen = 1'b1;
                        chk("stop-to-pulse latency", cyc - last_fall_cyc, LAT);
                    end
                end
            end
            ps2_clk_in = 1'b1;
            if (i == rst_bit) begin
                repeat (5) @(negedge CLOCK_50);
                resetn = 1'b0;
                repeat (3) @(negedge CLOCK_50);
                resetn = 1'b1;
            end
        end
        if (want) chk("frame pulse seen", int'(seen), 1);
    endtask

    initial begin
        repeat (90000) @(posedge CLOCK_50);
        $display("FAIL watchdog: cycle budget exhausted at %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_to;
        resetn = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chk("lit reset busy", int'(busy), 0);
        resetn = 1'b1;
        repeat (20) @(negedge CLOCK_50);

        // 1: slow clean frame, 4000-cycle bit period
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 2000, -1, -1);
        chk("lit t1 rx_data", int'(rx_data), 8'h1C);
        chk("lit t1 err_code", int'(err_code), 0);

        // 2: back-to-back frames
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, 50, -1, -1);
        chk("lit t2 rx_data F0", int'(rx_data), 8'hF0);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 50, -1, -1);
        chk("lit t2 rx_data 1C", int'(rx_data), 8'h1C);

        // 3: bad parity, then missing stop bit
        send_frame(8'h1C, 1'b1, 1'b1, 11, 50, -1, -1);
        chk("lit t3 parity code", int'(err_code), 2'b01);
        chk("lit t3 rx_data kept", int'(rx_data), 8'h1C);
        send_frame(8'h1C, odd_par(8'h1C), 1'b0, 11, 50, -1, -1);
        chk("lit t3 framing code", int'(err_code), 2'b10);

        // 4: short glitches on the clock line
        repeat (30) @(negedge CLOCK_50);
        ps2_clk_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        ps2_clk_in = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        chk("lit t4 idle glitch busy", int'(busy), 0);
        send_frame(8'h75, odd_par(8'h75), 1'b1, 11, 50, 4, -1);
        chk("lit t4 rx_data", int'(rx_data), 8'h75);

        // 5: stalled frame times out, then a clean frame
        q.push_back('{is_err: 1'b1, data: 8'h00, code: 2'b11});
        send_frame(8'hA5, 1'b0, 1'b1, 6, 50, -1, -1);
        ps2_dat_in = 1'b1;
        chk("lit t5 busy mid-frame", int'(busy), 1);
        seen_to = 1'b0;
        while (!seen_to && cyc < last_fall_cyc + LAT + TMO + 100) begin
            @(negedge CLOCK_50);
            if (rx_err) begin
                seen_to = 1'b1;
                chk("timeout latency", cyc - last_fall_cyc, LAT + TMO);
            end
        end
        chk("timeout pulse seen", int'(seen_to), 1);
        @(negedge CLOCK_50);
        chk("lit t5 timeout code", int'(err_code), 2'b11);
        chk("lit t5 busy", int'(busy), 0);
        repeat (20) @(negedge CLOCK_50);
        send_frame(8'hE0, odd_par(8'hE0), 1'b1, 11, 50, -1, -1);
        chk("lit t5 rx_data", int'(rx_data), 8'hE0);

        // 6: reset during data bit 4; the rest of that frame is ignored
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, 50, -1, 5);
        chk("lit t6 rx_data cleared", int'(rx_data), 0);
        chk("lit t6 err_code cleared", int'(err_code), 0);
        chk("lit t6 busy", int'(busy), 0);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 50, -1, -1);
        chk("lit t6 rx_data", int'(rx_data), 8'h1C);

        repeat (50) @(negedge CLOCK_50);
        chk("expected events left", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_rx_deserializer.md
Name: ps2_rx_deserializer

Overview:
Receive-only PS/2 device-to-host deserializer that sits directly upstream of the demo's hex display path.
- Synchronises and glitch-filters the PS/2 clock and data lines.
- Frames 11-bit packets: start, 8 data bits LSB first, odd parity, stop.
- Presents each good byte with a one-cycle valid strobe, for scan-code display on HEX via hex_decoder and for LEDR status.
- Tri-state handling of the PS2_CLK/PS2_DAT inout pins stays at top level; this block only reads them.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on both PS/2 lines (min 2).
FILTER_LEN, 8, consecutive CLOCK_50 cycles a synchronised PS/2 clock level must hold before the filtered clock follows it.
TIMEOUT_CYC, 100000, idle CLOCK_50 cycles mid-frame before abort (2 ms at 50 MHz).

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
resetn  input  1  asynchronous active-low reset.
ps2_clk_in  input  1  raw PS2_CLK pin level.
ps2_dat_in  input  1  raw PS2_DAT pin level.
rx_data  output  8  last correctly received byte.
rx_valid  output  1  one-cycle pulse; rx_data updated this cycle.
rx_err  output  1  one-cycle pulse on an aborted or bad frame.
err_code  output  2  01 parity, 10 framing (stop=0), 11 timeout; holds its value until the next rx_err.
busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, resetn=0):
  - rx_data=0x00, rx_valid=0, rx_err=0, err_code=00, busy=0.
  - State=IDLE; synchronisers and filtered clock set to 1 (bus idle); all counters 0.
  - Reset mid-frame discards the partial frame immediately. No pulse is emitted on reset release.
- Synchronisation: both lines pass through SYNC_STAGES flops.
- Filter:
  - A counter increments while the synced clock differs from the filtered clock, and clears when they match.
  - At FILTER_LEN, the filtered clock takes the synced level and the counter clears.
  - Glitches shorter than FILTER_LEN cycles are ignored.
- Sample strobe: one-cycle pulse on each 1->0 transition of the filtered clock. The synced data bit is sampled on that cycle.
- FSM states:
  - IDLE: on strobe, data=0 -> DATA with bit_cnt=0. Data=1 -> stay IDLE, no error.
  - DATA: on strobe, shift the sampled bit in at MSB of shift_reg (shift right), compute parity, bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: on strobe, store the parity bit -> STOP.
  - STOP: on strobe, resolve the frame and return to IDLE:
    - stop=1 and (XOR of data ^ parity)=1: rx_data<=shift_reg, rx_valid=1.
    - stop=1 and parity fails: rx_err=1, err_code=01, rx_data unchanged.
    - stop=0: rx_err=1, err_code=10 (framing takes priority over parity).
- Latency: rx_valid/rx_err assert on the cycle after the stop-bit strobe, for exactly 1 cycle.
- Timeout:
  - In any state except IDLE, a counter increments each cycle and clears on every strobe.
  - Reaching TIMEOUT_CYC -> rx_err=1, err_code=11, IDLE.
  - A strobe in the same cycle as the terminal count wins: no timeout, frame continues.
- Frame boundaries:
  - Back-to-back frames are supported with no dead cycles.
  - A strobe arriving on the cycle the FSM returns to IDLE is treated as a start-bit candidate.
- rx_valid and rx_err are never high together.

Test Plan:
1. Frame 0x1C, parity 0, stop 1, bit period 4000 cycles -> rx_valid single pulse one cycle after the stop strobe; rx_data=0x1C; busy falls with it; rx_err stays 0.
2. Back-to-back 0xF0 (parity 1) then 0x1C -> two rx_valid pulses; rx_data=0xF0 then 0x1C.
3. Frame 0x1C with parity 1 -> rx_err pulse, err_code=01, rx_data keeps its prior value, no rx_valid. Same frame with stop=0 -> err_code=10.
4. Glitches on ps2_clk_in: 3-cycle low while idle, and a 5-cycle high mid-bit (FILTER_LEN=8) -> no strobe, state unchanged. A following clean frame 0x75 is received correctly.
5. Frame stops after 5 data bits, lines idle high -> after TIMEOUT_CYC cycles rx_err pulse, err_code=11, busy=0. A subsequent 0xE0 frame gives rx_valid with rx_data=0xE0.
6. resetn pulsed low during bit 4 of a frame -> outputs cleared asynchronously. The remaining bits produce no pulse (bit 5 sampled as data=1 in IDLE, ignored). The next 0x1C frame is received cleanly.
